pd_onchip_burst_ram: RTL and testbench

Parametrised single-port on-chip RAM exposed as an Avalon-MM slave. It is the successor to the fixed 32-bit on-chip memory in the `pd` system. It adds configurable width, depth and read latency, pipelined reads with `readdatavalid`, incrementing bursts on both reads and writes, byte enables, and an optional hardware zero-fill after reset. It sits on the Nios II data/instruction interconnect, in place of the plain on-chip memory.

---
 rtl/pd_onchip_burst_ram_if.sv | 28 ++
 rtl/pd_onchip_burst_ram.sv | 131 +++++++++++++
 tb/tb_pd_onchip_burst_ram.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pd_onchip_burst_ram_if.sv
// Avalon-MM slave bus bundle for pd_onchip_burst_ram.
// The master drives commands and write beats; the slave returns read data and waitrequest.
interface pd_onchip_burst_ram_if #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 15,
    parameter int unsigned BURST_WIDTH = 4
);
    logic                      chipselect;
    logic                      read;
    logic                      write;
    logic [ADDR_WIDTH-1:0]     address;
    logic [BURST_WIDTH-1:0]    burstcount;
    logic [DATA_WIDTH/8-1:0]   byteenable;
    logic [DATA_WIDTH-1:0]     writedata;
    logic [DATA_WIDTH-1:0]     readdata;
    logic                      readdatavalid;
    logic                      waitrequest;

    modport master (
        output chipselect, read, write, address, burstcount, byteenable, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  chipselect, read, write, address, burstcount, byteenable, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/pd_onchip_burst_ram.sv
// Single-port on-chip RAM behind an Avalon-MM slave with incrementing bursts,
// byte enables, pipelined reads and an optional zero-fill sweep after reset.
module pd_onchip_burst_ram #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 15,
    parameter int unsigned DEPTH          = 25024,
    parameter int unsigned BURST_WIDTH    = 4,
    parameter int unsigned READ_LATENCY   = 1,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clken,
    pd_onchip_burst_ram_if.slave  bus
);
    localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
    localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {StClear, StIdle, StRburst, StWburst} state_e;

    state_e                  state_q;
    logic                    wait_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [BURST_WIDTH-1:0]  rem_q;
    logic [IDX_W-1:0]        clr_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic                    vld_q [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   dat_q [READ_LATENCY];

    logic                    accept;
    logic                    rd_beat;
    logic                    wr_beat;
    logic                    clr_beat;
    logic                    in_range;
    logic [ADDR_WIDTH-1:0]   beat_addr;
    logic [IDX_W-1:0]        beat_idx;
    logic [BURST_WIDTH-1:0]  bc_eff;

    always_comb begin
        accept    = !reset && clken && !wait_q && (state_q == StIdle) && bus.chipselect &&
                    (bus.read || bus.write);
        // First beat uses the bus address; later beats use the latched, incremented one.
        beat_addr = (state_q == StIdle) ? bus.address : addr_q;
        in_range  = 32'(beat_addr) < DEPTH;
        beat_idx  = beat_addr[IDX_W-1:0];
        bc_eff    = (bus.burstcount == '0) ? BURST_WIDTH'(1) : bus.burstcount;
        rd_beat   = (accept && !bus.write) ||
                    (!reset && clken && (state_q == StRburst));
        wr_beat   = (accept && bus.write) ||
                    (!reset && clken && (state_q == StWburst) && bus.chipselect && bus.write);
        clr_beat  = !reset && clken && (state_q == StClear);
    end

    always_ff @(posedge clk) begin
        if (clr_beat) begin
            mem[clr_q] <= '0;
        end else if (wr_beat && in_range) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (bus.byteenable[b]) begin
                    mem[beat_idx][8*b +: 8] <= bus.writedata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CLEAR_ON_RESET ? StClear : StIdle;
            wait_q  <= 1'b1;
            addr_q  <= '0;
            rem_q   <= '0;
            clr_q   <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                vld_q[i] <= 1'b0;
                dat_q[i] <= '0;
            end
        end else if (clken) begin
            vld_q[0] <= rd_beat;
            if (rd_beat) begin
                dat_q[0] <= in_range ? mem[beat_idx] : '0;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end

            unique case (state_q)
                StClear: begin
                    clr_q <= clr_q + IDX_W'(1);
                    if (clr_q == IDX_W'(DEPTH - 1)) begin
                        state_q <= StIdle;
                        wait_q  <= 1'b0;
                    end
                end
                StIdle: begin
                    wait_q <= 1'b0;
                    if (accept) begin
                        addr_q <= bus.address + ADDR_WIDTH'(1);
                        rem_q  <= bc_eff - BURST_WIDTH'(1);
                        if (bc_eff > BURST_WIDTH'(1)) begin
                            state_q <= bus.write ? StWburst : StRburst;
                            wait_q  <= !bus.write;
                        end
                    end
                end
                StRburst: begin
                    addr_q <= addr_q + ADDR_WIDTH'(1);
                    rem_q  <= rem_q - BURST_WIDTH'(1);
                    if (rem_q == BURST_WIDTH'(1)) begin
                        state_q <= StIdle;
                        wait_q  <= 1'b0;
                    end
                end
                StWburst: begin
                    if (wr_beat) begin
                        addr_q <= addr_q + ADDR_WIDTH'(1);
                        rem_q  <= rem_q - BURST_WIDTH'(1);
                        if (rem_q == BURST_WIDTH'(1)) begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.readdata      = dat_q[READ_LATENCY-1];
    assign bus.readdatavalid = vld_q[READ_LATENCY-1];
    assign bus.waitrequest   = wait_q || !clken;
endmodule

// File: tb/tb_pd_onchip_burst_ram.sv
// Directed bench: two instances share one stimulus stream; dut_a is DEPTH=16 with
// READ_LATENCY=2, dut_b is DEPTH=32 with READ_LATENCY=1.
module tb_pd_onchip_burst_ram;
    logic        clk = 1'b0;
    logic        reset;
    logic        clken;
    logic        cs, rd, wr;
    logic [14:0] addr;
    logic [3:0]  bc;
    logic [3:0]  be;
    logic [31:0] wd;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int acc_k;
    int wcnt_a;
    int ca, cb;
    bit prev_en = 1'b0;

    logic [31:0] qa_d[$];
    logic [31:0] qb_d[$];
    int          qa_c[$];
    int          qb_c[$];

    pd_onchip_burst_ram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(15), .BURST_WIDTH(4)) bus_a ();
    pd_onchip_burst_ram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(15), .BURST_WIDTH(4)) bus_b ();

    assign bus_a.chipselect = cs;
    assign bus_a.read       = rd;
    assign bus_a.write      = wr;
    assign bus_a.address    = addr;
    assign bus_a.burstcount = bc;
    assign bus_a.byteenable = be;
    assign bus_a.writedata  = wd;
    assign bus_b.chipselect = cs;
    assign bus_b.read       = rd;
    assign bus_b.write      = wr;
    assign bus_b.address    = addr;
    assign bus_b.burstcount = bc;
    assign bus_b.byteenable = be;
    assign bus_b.writedata  = wd;

    pd_onchip_burst_ram #(
        .DATA_WIDTH(32), .ADDR_WIDTH(15), .DEPTH(16), .BURST_WIDTH(4),
        .READ_LATENCY(2), .CLEAR_ON_RESET(1'b1)
    ) dut_a (
        .clk(clk), .reset(reset), .clken(clken), .bus(bus_a)
    );

    pd_onchip_burst_ram #(
        .DATA_WIDTH(32), .ADDR_WIDTH(15), .DEPTH(32), .BURST_WIDTH(4),
        .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1)
    ) dut_b (
        .clk(clk), .reset(reset), .clken(clken), .bus(bus_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        prev_en <= clken;
    end

    // A beat is new only if the edge that produced it was enabled.
    always @(negedge clk) begin
        if (!reset && prev_en) begin
            if (bus_a.readdatavalid) begin
                qa_d.push_back(bus_a.readdata);
                qa_c.push_back(cyc);
            end
            if (bus_b.readdatavalid) begin
                qb_d.push_back(bus_b.readdata);
                qb_c.push_back(cyc);
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic qclear();
        qa_d.delete();
        qa_c.delete();
        qb_d.delete();
        qb_c.delete();
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!bus_a.waitrequest && !bus_b.waitrequest) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) check_eq("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic measure_clear(output int na, output int nb);
        bit done_a = 1'b0;
        bit done_b = 1'b0;
        na = 0;
        nb = 0;
        for (int i = 0; i < 80; i++) begin
            if (!done_a) begin
                if (bus_a.waitrequest) na++;
                else done_a = 1'b1;
            end
            if (!done_b) begin
                if (bus_b.waitrequest) nb++;
                else done_b = 1'b1;
            end
            if (done_a && done_b) break;
            step();
        end
    endtask

    task automatic write_word(input logic [14:0] a, input logic [3:0] bytes, input logic [31:0] d);
        wait_idle();
        cs = 1'b1; wr = 1'b1; addr = a; bc = 4'd1; be = bytes; wd = d;
        step();
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic read_burst(input logic [14:0] a, input logic [3:0] n);
        wait_idle();
        qclear();
        acc_k = cyc;
        cs = 1'b1; rd = 1'b1; addr = a; bc = n;
        step();
        cs = 1'b0; rd = 1'b0;
        wcnt_a = 0;
        repeat (int'(n) + 6) begin
            if (bus_a.waitrequest) wcnt_a++;
            step();
        end
    endtask

    task automatic check_beats(input bit sel, input string tag, input int n,
                               input logic [31:0] base, input logic [31:0] incr);
        int sz = sel ? qb_d.size() : qa_d.size();
        check_eq({tag, "_count"}, 32'(sz), 32'(n));
        for (int i = 0; i < n && i < sz; i++) begin
            check_eq(tag, sel ? qb_d[i] : qa_d[i], base + 32'(i) * incr);
        end
    endtask

    initial begin
        reset = 1'b1; clken = 1'b1;
        cs = 1'b0; rd = 1'b0; wr = 1'b0;
        addr = '0; bc = 4'd1; be = 4'hF; wd = '0;
        repeat (3) step();

        check_eq("rst_rdv_a", 32'(bus_a.readdatavalid), 32'd0);
        check_eq("rst_rdata_a", bus_a.readdata, 32'd0);
        check_eq("rst_wait_a", 32'(bus_a.waitrequest), 32'd1);
        check_eq("rst_wait_b", 32'(bus_b.waitrequest), 32'd1);

        reset = 1'b0;
        measure_clear(ca, cb);
        check_eq("clear_len_a", 32'(ca), 32'd16);
        check_eq("clear_len_b", 32'(cb), 32'd32);

        read_burst(15'd0, 4'd8);
        check_beats(1'b0, "zero_lo_a", 8, 32'd0, 32'd0);
        read_burst(15'd8, 4'd8);
        check_beats(1'b0, "zero_hi_a", 8, 32'd0, 32'd0);

        write_word(15'd5, 4'hF, 32'hAABBCCDD);
        write_word(15'd5, 4'h5, 32'h11223344);
        read_burst(15'd5, 4'd1);
        check_beats(1'b0, "byteen_a", 1, 32'hAA22CC44, 32'd0);
        check_beats(1'b1, "byteen_b", 1, 32'hAA22CC44, 32'd0);

        for (int i = 0; i < 4; i++) write_word(15'(8 + i), 4'hF, 32'(i + 1));
        read_burst(15'd8, 4'd4);
        check_beats(1'b0, "rburst_a", 4, 32'd1, 32'd1);
        check_beats(1'b1, "rburst_b", 4, 32'd1, 32'd1);
        if (qa_c.size() == 4) begin
            check_eq("rburst_lat_a", 32'(qa_c[0] - acc_k), 32'd2);
            check_eq("rburst_span_a", 32'(qa_c[3] - qa_c[0]), 32'd3);
        end
        if (qb_c.size() == 4) check_eq("rburst_lat_b", 32'(qb_c[0] - acc_k), 32'd1);
        check_eq("rburst_wait_a", 32'(wcnt_a), 32'd3);

        // Write burst with one idle gap; the address bus is scrambled after the first beat.
        wait_idle();
        cs = 1'b1; wr = 1'b1; addr = 15'd20; bc = 4'd3; be = 4'hF; wd = 32'd7;
        step();
        cs = 1'b0; wr = 1'b0; addr = 15'd0; bc = 4'd1; wd = 32'd0;
        step();
        cs = 1'b1; wr = 1'b1; wd = 32'd8;
        step();
        wd = 32'd9;
        step();
        cs = 1'b0; wr = 1'b0;
        read_burst(15'd20, 4'd3);
        check_beats(1'b1, "wburst_b", 3, 32'd7, 32'd1);
        check_beats(1'b0, "wburst_oor_a", 3, 32'd0, 32'd0);

        write_word(15'd17, 4'hF, 32'hDEADBEEF);
        read_burst(15'd17, 4'd1);
        check_beats(1'b0, "oor_rd_a", 1, 32'd0, 32'd0);
        check_beats(1'b1, "oor_b", 1, 32'hDEADBEEF, 32'd0);
        read_burst(15'd1, 4'd1);
        check_beats(1'b0, "oor_alias_a", 1, 32'd0, 32'd0);

        wait_idle();
        qclear();
        acc_k = cyc;
        cs = 1'b1; rd = 1'b1; addr = 15'd8; bc = 4'd4;
        step();
        cs = 1'b0; rd = 1'b0;
        step();
        step();
        clken = 1'b0;
        check_eq("clken_wait_a", 32'(bus_a.waitrequest), 32'd1);
        repeat (3) step();
        clken = 1'b1;
        repeat (8) step();
        check_beats(1'b0, "clken_a", 4, 32'd1, 32'd1);
        if (qa_c.size() == 4) begin
            check_eq("clken_lat_a", 32'(qa_c[0] - acc_k), 32'd2);
            check_eq("clken_span_a", 32'(qa_c[3] - qa_c[0]), 32'd6);
        end

        wait_idle();
        qclear();
        cs = 1'b1; rd = 1'b1; addr = 15'd0; bc = 4'd8;
        step();
        cs = 1'b0; rd = 1'b0;
        step();
        step();
        reset = 1'b1;
        qclear();
        step();
        step();
        reset = 1'b0;
        measure_clear(ca, cb);
        check_eq("reclear_len_a", 32'(ca), 32'd16);
        repeat (4) step();
        check_eq("no_rdv_after_rst_a", 32'(qa_d.size()), 32'd0);
        check_eq("no_rdv_after_rst_b", 32'(qb_d.size()), 32'd0);
        read_burst(15'd8, 4'd1);
        check_beats(1'b0, "reclear_a", 1, 32'd0, 32'd0);
        check_beats(1'b1, "reclear_b", 1, 32'd0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
